// File: rtl/pkg_system_mdr.sv
// Shared types and width helpers for the radix-4 Booth multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, Booth recode-select enum, parametric width helpers.
package pkg_system_mdr;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } mdr_state_t;

  // Partial-product selection produced by the recoder for one radix-4 digit.
  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    ADD_M  = 3'd1,
    ADD_2M = 3'd2,
    SUB_M  = 3'd3,
    SUB_2M = 3'd4
  } rsel_t;

  // Operands carry two extra bits so unsigned values recode as non-negative
  // and the digit count comes out even.
  function automatic int ext_w(input int dw);
    return dw + 2;
  endfunction

  // Upper accumulator: wide enough that adding +/-2M to any partial sum
  // cannot wrap before the arithmetic shift.
  function automatic int acc_w(input int dw);
    return dw + 4;
  endfunction

  // Number of radix-4 digits in the extended multiplier.
  function automatic int n_iter(input int dw);
    return dw / 2 + 1;
  endfunction

  // Counter must reach n_iter(dw) itself (final capture cycle).
  function automatic int cnt_w(input int dw);
    return $clog2(dw / 2 + 2);
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Maps a radix-4 Booth triplet {p1, p0, q_-1} onto a partial-product select.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: i_triplet [2:0] in  - {P[1], P[0], q_-1}
//        o_sel   rsel_t  out - ZERO / ADD_M / ADD_2M / SUB_M / SUB_2M
module booth_r4_recoder
  import pkg_system_mdr::*;
(
  input  logic [2:0] i_triplet,
  output rsel_t      o_sel
);

  always_comb begin
    o_sel = ZERO;
    case (i_triplet)
      3'b000:  o_sel = ZERO;
      3'b001:  o_sel = ADD_M;
      3'b010:  o_sel = ADD_M;
      3'b011:  o_sel = ADD_2M;
      3'b100:  o_sel = SUB_2M;
      3'b101:  o_sel = SUB_M;
      3'b110:  o_sel = SUB_M;
      3'b111:  o_sel = ZERO;
      default: o_sel = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier, signed or unsigned DW x DW -> 2*DW.
// Latency: o_done DW/2+2 edges after the accepting edge, o_ready one edge later.
// Backpressure: i_start only honoured while o_ready=1; i_clear aborts.
//
// Ports: clk, rst (async, active-low)
//        i_start, i_signed, i_multiplier[DW], i_multiplicand[DW] - request
//        i_clear                                                  - abort
//        o_ready, o_busy, o_done (1-cycle pulse), o_result[2*DW]  - status/product
module booth_r4_multiplier
  import pkg_system_mdr::*;
#(
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_signed,
  input  logic [DW-1:0]     i_multiplier,
  input  logic [DW-1:0]     i_multiplicand,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*DW-1:0]   o_result
);

  localparam int XW = ext_w(DW);
  localparam int AW = acc_w(DW);
  localparam int NI = n_iter(DW);
  localparam int CW = cnt_w(DW);
  localparam logic [CW-1:0] LAST = CW'(NI);

  mdr_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [XW-1:0]        p_q, p_d;
  logic                 qm1_q, qm1_d;
  logic [XW-1:0]        m_q, m_d;
  logic [2*DW-1:0]      result_q, result_d;

  rsel_t                sel;
  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        m_x2;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_sum;
  logic [XW-1:0]        mplr_ext;
  logic [XW-1:0]        mcnd_ext;

  booth_r4_recoder u_recoder (
    .i_triplet ({p_q[1], p_q[0], qm1_q}),
    .o_sel     (sel)
  );

  // Operand extension at load: the two extra bits are copies of the sign in
  // signed mode and zeros in unsigned mode.
  always_comb begin
    mplr_ext = i_signed ? {{2{i_multiplier[DW-1]}}, i_multiplier}
                        : {2'b00, i_multiplier};
    mcnd_ext = i_signed ? {{2{i_multiplicand[DW-1]}}, i_multiplicand}
                        : {2'b00, i_multiplicand};
  end

  // One Booth step: add the selected multiple of M into the upper accumulator.
  always_comb begin
    m_ext  = {{(AW-XW){m_q[XW-1]}}, m_q};
    m_x2   = {m_ext[AW-2:0], 1'b0};
    addend = '0;
    case (sel)
      ZERO:    addend = '0;
      ADD_M:   addend = m_ext;
      ADD_2M:  addend = m_x2;
      SUB_M:   addend = {AW{1'b0}} - m_ext;
      SUB_2M:  addend = {AW{1'b0}} - m_x2;
      default: addend = '0;
    endcase
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    p_d      = p_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        // i_clear is meaningless here; only i_start matters.
        if (i_start) begin
          state_d = ST_ITER;
          cnt_d   = '0;
          acc_d   = '0;
          p_d     = mplr_ext;
          qm1_d   = 1'b0;
          m_d     = mcnd_ext;
        end
      end

      ST_ITER: begin
        if (i_clear) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LAST) begin
          // All digits consumed: {acc, P} now holds the full product.
          result_d = {acc_q[DW-3:0], p_q};
          state_d  = ST_DONE;
        end else begin
          // Arithmetic shift of {acc_sum, P, q_-1} right by two.
          acc_d = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
          p_d   = {acc_sum[1:0], p_q[XW-1:2]};
          qm1_d = p_q[1];
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = (state_q == ST_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
module tb_booth_r4_multiplier;

  localparam int DW = 16;
  localparam int LAT = DW / 2 + 2;  // edges from acceptance to o_done

  logic            clk;
  logic            rst;
  logic            i_start;
  logic            i_signed;
  logic [DW-1:0]   i_multiplier;
  logic [DW-1:0]   i_multiplicand;
  logic            i_clear;
  logic            o_ready;
  logic            o_busy;
  logic            o_done;
  logic [2*DW-1:0] o_result;

  int errors = 0;
  int checks = 0;

  booth_r4_multiplier #(.DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_signed       (i_signed),
    .i_multiplier   (i_multiplier),
    .i_multiplicand (i_multiplicand),
    .i_clear        (i_clear),
    .o_ready        (o_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_result       (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product computed with plain 64-bit integer arithmetic.
  function automatic logic [31:0] ref_mul(input bit s, input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    logic [63:0] pv;
    x  = s ? longint'($signed(a)) : longint'({48'b0, a});
    y  = s ? longint'($signed(b)) : longint'({48'b0, b});
    p  = x * y;
    pv = p;
    return pv[31:0];
  endfunction

  // Present a request at a falling edge; returns after the accepting rising edge (+1).
  task automatic issue(input bit s, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    i_start        = 1'b1;
    i_signed       = s;
    i_multiplier   = a;
    i_multiplicand = b;
    @(posedge clk);
    #1;
    i_start        = 1'b0;
    // Scramble the operand inputs: the running operation must not notice.
    i_multiplier   = DW'($urandom);
    i_multiplicand = DW'($urandom);
    i_signed       = 1'($urandom);
  endtask

  // Watch up to 'limit' edges; optionally inject a stray i_start (2x2) before edge inj_at.
  task automatic watch(input int limit, input int inj_at, output int first, output int ndone);
    first = 0;
    ndone = 0;
    for (int e = 1; e <= limit; e++) begin
      @(negedge clk);
      if (e == inj_at) begin
        i_start        = 1'b1;
        i_multiplier   = 16'd2;
        i_multiplicand = 16'd2;
      end else begin
        i_start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (o_done) begin
        ndone++;
        if (first == 0) first = e;
      end
    end
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_op(input string tag, input bit s, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    int first;
    int got_done;
    got_done = 0;
    first    = 0;
    @(negedge clk);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    issue(s, a, b);
    check({tag, "_busy"}, 64'(o_busy), 64'd1);
    for (int e = 1; e <= LAT + 6; e++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        first    = e;
        got_done = 1;
        break;
      end
    end
    check({tag, "_lat"}, 64'(first), 64'(LAT));
    if (got_done != 0) begin
      check({tag, "_res"}, 64'(o_result), 64'(exp));
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, {62'd0, o_done, o_ready}, 64'd1);
      check({tag, "_hold"}, 64'(o_result), 64'(exp));
    end
  endtask

  initial begin
    int first, ndone;
    logic [31:0] prev;
    logic [15:0] a, b;
    bit s;
    logic [15:0] special [5];
    special[0] = 16'h8000; special[1] = 16'h7FFF; special[2] = 16'hFFFF;
    special[3] = 16'h0000; special[4] = 16'h0001;

    rst = 1'b0; i_start = 1'b0; i_signed = 1'b0; i_clear = 1'b0;
    i_multiplier = '0; i_multiplicand = '0;
    #1;
    check("rst_ready",  64'(o_ready),  64'd1);
    check("rst_busy",   64'(o_busy),   64'd0);
    check("rst_done",   64'(o_done),   64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op("s_3x5",       1'b1, 16'd3,     16'd5,     32'h0000_000F);
    run_op("s_min_x_min", 1'b1, 16'h8000,  16'h8000,  32'h4000_0000);
    run_op("s_m1_x_2",    1'b1, 16'hFFFF,  16'h0002,  32'hFFFF_FFFE);
    run_op("u_max_x_max", 1'b0, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001);
    run_op("s_max_x_min", 1'b1, 16'h7FFF,  16'h8000,  32'hC000_8000);
    run_op("u_min_x_min", 1'b0, 16'h8000,  16'h8000,  32'h4000_0000);

    // Stray i_start during ITER must be ignored.
    issue(1'b1, 16'd7, 16'd9);
    watch(LAT + 8, 3, first, ndone);
    check("ign_start_lat",   64'(first), 64'(LAT));
    check("ign_start_ndone", 64'(ndone), 64'd1);
    check("ign_start_res",   64'(o_result), 64'h3F);
    prev = o_result;

    // i_clear while idle: nothing happens.
    @(negedge clk);
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    check("idle_clr_ready", 64'(o_ready), 64'd1);
    check("idle_clr_res",   64'(o_result), 64'(prev));

    // Abort with i_clear three cycles into ITER.
    issue(1'b1, 16'd100, 16'd200);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    check("clr_ready", 64'(o_ready), 64'd1);
    check("clr_busy",  64'(o_busy),  64'd0);
    check("clr_res",   64'(o_result), 64'(prev));
    watch(LAT + 4, 0, first, ndone);
    check("clr_no_done", 64'(ndone), 64'd0);
    check("clr_res2",    64'(o_result), 64'(prev));

    // Asynchronous reset three cycles into ITER.
    issue(1'b0, 16'h1234, 16'h5678);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_ready", 64'(o_ready),  64'd1);
    check("mrst_busy",  64'(o_busy),   64'd0);
    check("mrst_done",  64'(o_done),   64'd0);
    check("mrst_res",   64'(o_result), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    watch(LAT + 4, 0, first, ndone);
    check("mrst_no_done", 64'(ndone), 64'd0);
    check("mrst_ready2",  64'(o_ready), 64'd1);

    // Randomised operands, biased toward extreme values.
    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : 16'($urandom);
      run_op($sformatf("rnd%0d_%s_%h_%h", k, s ? "s" : "u", a, b), s, a, b, ref_mul(s, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_r4_multiplier.md
BOOTH_R4_MULTIPLIER -- requirements
Module: booth_r4_multiplier

Interface
REQ-001 SHALL have parameter DW, default 16: operand width; legal values are even and 4..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_start, input, 1 bit: request a multiply; accepted only when o_ready=1.
REQ-005 SHALL have port i_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with i_start.
REQ-006 SHALL have port i_multiplier, input, DW bits: multiplier operand; sampled with i_start.
REQ-007 SHALL have port i_multiplicand, input, DW bits: multiplicand operand; sampled with i_start.
REQ-008 SHALL have port i_clear, input, 1 bit: synchronous abort of an operation in progress.
REQ-009 SHALL have port o_ready, output, 1 bit: idle and able to accept i_start.
REQ-010 SHALL have port o_busy, output, 1 bit: operation in progress.
REQ-011 SHALL have port o_done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port o_result, output, 2*DW bits: product, held until the next completion.

Function
REQ-013 SHALL implement FSM states IDLE, ITER and DONE.
REQ-014 IDLE: o_ready=1. On i_start=1 the block SHALL load the operands and go to ITER at the next edge.
REQ-015 On load, both operands SHALL be extended to DW+2 bits: sign-extended if i_signed=1, zero-extended if i_signed=0.
REQ-016 ITER SHALL run exactly N = DW/2+1 cycles, counted by an iteration counter that is cleared on load.
REQ-017 Each ITER cycle SHALL recode the triplet {P[1], P[0], q_-1} to a value in {0, +M, +2M, -M, -2M}.
REQ-018 Each ITER cycle SHALL add that value to the upper accumulator, then arithmetic-shift {acc, P, q_-1} right by 2.
REQ-019 The upper accumulator SHALL be DW+4 bits wide, so that ±2M never overflows.
REQ-020 After the Nth ITER cycle the FSM SHALL enter DONE; o_result SHALL take the low 2*DW bits of the product; o_done=1 for exactly one cycle.
REQ-021 DONE SHALL return to IDLE unconditionally at the next edge.
REQ-022 Latency: with i_start accepted at edge k, o_done SHALL be high in the cycle after edge k+N+1; o_ready SHALL return in the cycle after edge k+N+2.
REQ-023 o_busy SHALL be 1 in ITER and DONE, and 0 in IDLE.
REQ-024 i_start while not in IDLE SHALL be ignored, with no effect on the running operation.
REQ-025 i_clear=1 in ITER or DONE SHALL force IDLE at the next edge, with no o_done and o_result unchanged.
REQ-026 i_clear has priority over i_start.
REQ-027 i_clear in IDLE SHALL have no effect.
REQ-028 Operand changes after acceptance SHALL NOT affect the result.
REQ-029 The result SHALL be exact for every operand pair in both modes, including the most-negative value times itself.

Reset
REQ-030 rst=0 SHALL asynchronously force the FSM to IDLE and clear the counter, accumulator, and P and q_-1 registers.
REQ-031 During reset, outputs SHALL be: o_result=0, o_done=0, o_busy=0, o_ready=1.
REQ-032 Reset asserted mid-operation SHALL abandon the operation; no o_done SHALL follow reset release.

Structure
REQ-033 The package pkg_system_mdr SHALL hold:
- the FSM state enum;
- the recode-select enum (ZERO, ADD_M, ADD_2M, SUB_M, SUB_2M);
- the parametric width helpers.
REQ-034 A combinational sub-module booth_r4_recoder SHALL map the 3-bit triplet to the recode select; the FSM and datapath reside in the top.

Verification
REQ-035 DW=16, signed: 3 × 5 -> o_result=0x0000_000F; o_done exactly 10 edges after acceptance.
REQ-036 DW=16, signed: 0x8000 × 0x8000 -> 0x4000_0000.
REQ-037 DW=16, signed: 0xFFFF × 0x0002 -> 0xFFFF_FFFE.
REQ-038 DW=16, unsigned: 0xFFFF × 0xFFFF -> 0xFFFE_0001.
REQ-039 DW=16: start 7 × 9; pulse i_start with 2 × 2 during ITER -> single o_done with 0x0000_003F.
REQ-040 DW=16: i_clear, or reset, asserted 3 cycles into ITER -> no o_done; o_ready=1 next cycle; prior o_result retained on clear, 0 after reset.
